// File: rtl/fetch_pkg.sv
// Shared types and constants for the word-addressed instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Word addressing: the successor of a PC is simply PC+1, wrapping modulo 2^32.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: branch beats jump, otherwise sequential PC+1.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect
);

    always_comb begin
        pc_plus1 = pc_inc(pc);
        redirect = branch_taken || jump;
        next_pc  = pc_plus1;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight and
// registers each returned word into the IF/ID output.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    fetch_if.master         imem,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_next_pc
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic            if_valid_q;
    logic [31:0]     if_instr_q;
    logic [PC_W-1:0] if_pc_q;
    logic [PC_W-1:0] if_next_pc_q;

    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_d;
    logic            redirect;
    logic            handshake;

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_plus1      (pc_plus1),
        .next_pc       (pc_d),
        .redirect      (redirect)
    );

    // Never request while a stalled instruction is parked in IF/ID, so a
    // response always finds the output register free.
    assign imem.imem_req  = (state_q == REQ) && !(if_valid_q && stall_in);
    assign imem.imem_addr = pc_q;
    assign handshake      = imem.imem_req && imem.imem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_next_pc_q <= '0;
        end else begin
            if (if_valid_q && !stall_in) begin
                if_valid_q <= 1'b0;
            end

            unique case (state_q)
                REQ: begin
                    if (handshake) begin
                        state_q <= redirect ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state_q <= imem.imem_rvalid ? REQ : DRAIN;
                    end else if (imem.imem_rvalid) begin
                        if_instr_q   <= imem.imem_rdata;
                        if_pc_q      <= pc_q;
                        if_next_pc_q <= pc_plus1;
                        if_valid_q   <= 1'b1;
                        pc_q         <= pc_plus1;
                        state_q      <= REQ;
                    end
                end
                DRAIN: begin
                    // The wrong-path response retires the only outstanding
                    // request; a redirect in the same cycle has already moved pc.
                    if (imem.imem_rvalid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase

            if (redirect) begin
                pc_q       <= pc_d;
                if_valid_q <= 1'b0;
            end
        end
    end

    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_next_pc = if_next_pc_q;

endmodule
